period_meter: RTL and testbench

// - Receiving end of the divided-clock path: samples a slow, asynchronous square wave
//   (e.g. the output of the clock divider) in the fast clock domain.
// - Produces one-cycle rise/fall strobes and measures the rising-edge-to-rising-edge period
//   in clk cycles.
// - Flags loss of signal. Feeds sequencing logic that needs enables and frequency checks.

---
 rtl/sequent_pkg.sv | 13 +
 rtl/edge_sync.sv | 34 +++
 rtl/period_meter.sv | 111 +++++++++++
 tb/tb_period_meter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sequent_pkg.sv
// Shared types for the divided-clock receive path: period meter FSM states
// and synchronizer depth.
package sequent_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_LOST    = 2'd2
    } state_t;

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous level into the clk domain and emits registered
// one-cycle rise/fall strobes; q is the synchronized level.
module edge_sync
    import sequent_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   lvl;

    assign lvl = sync[SYNC_STAGES-1];

    // Strobes are registered alongside q, so they land on the 3rd edge after d moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            q    <= lvl;
            rise <= lvl & ~q;
            fall <= ~lvl & q;
        end
    end

endmodule

// File: rtl/period_meter.sv
// Measures the rising-edge-to-rising-edge period of a slow asynchronous square
// wave in clk cycles, with a valid/ack handshake, overrun flag and loss detect.
module period_meter
    import sequent_pkg::*;
#(
    parameter int         N       = 26,
    parameter logic [N:0] TIMEOUT = 27'd50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig,
    output logic       rise,
    output logic       fall,
    output logic [N:0] period,
    output logic       period_valid,
    input  logic       ack,
    output logic       overrun,
    output logic       lost
);

    localparam logic [N:0] ONE        = (N+1)'(1);
    localparam logic [N:0] CNT_MAX    = '1;
    localparam logic [N:0] TIMEOUT_M1 = TIMEOUT - ONE;

    state_t     state, state_nxt;
    logic [N:0] cnt, cnt_nxt;
    logic [N:0] period_nxt;
    logic       lost_nxt;
    logic       load;
    logic       ack_eff;
    logic       pv_nxt;
    logic       ov_nxt;
    logic       sig_q_unused;

    edge_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sig),
        .rise (rise),
        .fall (fall),
        .q    (sig_q_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
            lost         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= pv_nxt;
            overrun      <= ov_nxt;
            lost         <= lost_nxt;
        end
    end

    // Only S_MEASURE publishes; the arming edge out of IDLE/LOST has no valid start point.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_nxt  = lost;
        load      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    cnt_nxt   = '0;
                    state_nxt = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (rise) begin
                    load    = 1'b1;
                    cnt_nxt = '0;
                end else if (cnt == TIMEOUT_M1) begin
                    lost_nxt  = 1'b1;
                    state_nxt = S_LOST;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_LOST: begin
                if (rise) begin
                    lost_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = S_MEASURE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                lost_nxt  = 1'b0;
            end
        endcase
    end

    // An ack against an empty slot has nothing to consume.
    always_comb begin
        ack_eff    = ack & period_valid;
        period_nxt = period;
        if (load)
            period_nxt = (cnt == CNT_MAX) ? CNT_MAX : cnt + ONE;
        pv_nxt = load | (period_valid & ~ack_eff);
        ov_nxt = (load & period_valid & ~ack_eff) | (overrun & ~ack_eff);
    end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (N=15, TIMEOUT=100): strobe timing is
// scoreboarded, handshake/period/lost state is checked at fixed cycles.
module tb_period_meter;

    localparam int N = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sig = 1'b0;
    logic       ack = 1'b0;
    logic       rise, fall, period_valid, overrun, lost;
    logic [N:0] period;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;
    int rise_q[$];
    int fall_q[$];
    int t, s, u, v;

    period_meter #(.N(N), .TIMEOUT(16'd100)) dut (
        .clk          (clk),
        .rst          (rst),
        .sig          (sig),
        .rise         (rise),
        .fall         (fall),
        .period       (period),
        .period_valid (period_valid),
        .ack          (ack),
        .overrun      (overrun),
        .lost         (lost)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at a negedge: the synchronized strobe is due 3 posedges later.
    task automatic set_sig(input logic val);
        if (val && !sig) rise_q.push_back(cyc + 3);
        if (!val && sig) fall_q.push_back(cyc + 3);
        sig = val;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse_ack(input int at);
        run_to(at);
        ack = 1'b1;
        run_to(at + 1);
        ack = 1'b0;
    endtask

    always @(negedge clk) begin
        int e;
        if (rise) begin
            e = (rise_q.size() != 0) ? rise_q.pop_front() : -1;
            chk("rise_cycle", cyc, e);
        end
        if (fall) begin
            e = (fall_q.size() != 0) ? fall_q.pop_front() : -1;
            chk("fall_cycle", cyc, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held over several edges while sig toggles; nothing may leak out.
        @(negedge clk); sig = 1'b1;
        @(negedge clk); sig = 1'b0;
        @(negedge clk); sig = 1'b1;
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_period", period, 0);
        chk("rst_pv", period_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_lost", lost, 0);
        @(negedge clk); sig = 1'b0; rst = 1'b0;
        run_to(cyc + 2);

        // 10 high / 10 low wave: rise edges at t+0,20,40,60,80
        t = cyc;
        set_sig(1);
        run_to(t + 4);
        chk("arm_pv", period_valid, 0);
        chk("arm_period", period, 0);
        run_to(t + 10); set_sig(0);
        run_to(t + 20); set_sig(1);
        run_to(t + 24);
        chk("p20_period", period, 20);
        chk("p20_pv", period_valid, 1);
        chk("p20_overrun", overrun, 0);
        pulse_ack(t + 24);
        chk("ack_clears_pv", period_valid, 0);
        chk("ack_keeps_period", period, 20);
        run_to(t + 30); set_sig(0);
        run_to(t + 40); set_sig(1);
        run_to(t + 44);
        chk("r3_pv", period_valid, 1);
        chk("r3_overrun", overrun, 0);
        run_to(t + 50); set_sig(0);
        run_to(t + 60); set_sig(1);
        run_to(t + 64);
        chk("r4_overrun", overrun, 1);
        chk("r4_period", period, 20);
        chk("r4_pv", period_valid, 1);
        run_to(t + 70); set_sig(0);
        run_to(t + 80); set_sig(1);
        // ack lands with the 5th rise strobe
        pulse_ack(t + 83);
        chk("ackrise_pv", period_valid, 1);
        chk("ackrise_overrun", overrun, 0);
        run_to(t + 85);
        chk("ackrise_pv_hold", period_valid, 1);
        chk("ackrise_no_overrun", overrun, 0);
        run_to(t + 90); set_sig(0);

        // stuck low: last rise strobe at t+83
        run_to(t + 183);
        chk("lost_early", lost, 0);
        run_to(t + 184);
        chk("lost_set", lost, 1);
        chk("lost_period", period, 20);
        chk("lost_pv", period_valid, 1);
        pulse_ack(t + 184);
        chk("lost_ack_pv", period_valid, 0);

        // resume; rise edges at s+0, s+20, s+120 (100 apart), s+221 (101 apart), s+241
        s = t + 190;
        run_to(s); set_sig(1);
        run_to(s + 4);
        chk("rearm_lost", lost, 0);
        chk("rearm_pv", period_valid, 0);
        run_to(s + 10); set_sig(0);
        run_to(s + 20); set_sig(1);
        run_to(s + 24);
        chk("resume_period", period, 20);
        chk("resume_pv", period_valid, 1);
        pulse_ack(s + 24);
        run_to(s + 30); set_sig(0);
        run_to(s + 120); set_sig(1);
        run_to(s + 123);
        chk("b100_lost_pre", lost, 0);
        run_to(s + 124);
        chk("b100_period", period, 100);
        chk("b100_pv", period_valid, 1);
        chk("b100_lost", lost, 0);
        pulse_ack(s + 124);
        run_to(s + 130); set_sig(0);
        run_to(s + 221); set_sig(1);
        run_to(s + 223);
        chk("b101_lost_pre", lost, 0);
        run_to(s + 224);
        chk("b101_lost", lost, 1);
        run_to(s + 225);
        chk("b101_rearm_lost", lost, 0);
        chk("b101_rearm_pv", period_valid, 0);
        chk("b101_rearm_period", period, 100);
        run_to(s + 231); set_sig(0);
        run_to(s + 241); set_sig(1);
        run_to(s + 245);
        chk("after_rearm_period", period, 20);
        chk("after_rearm_pv", period_valid, 1);
        run_to(s + 251); set_sig(0);

        // 19-cycle gap with no ack -> overrun, then reset at cnt==7
        u = s + 260;
        run_to(u); set_sig(1);
        run_to(u + 4);
        chk("p19_period", period, 19);
        chk("p19_overrun", overrun, 1);
        run_to(u + 5); set_sig(0);
        run_to(u + 11); rst = 1'b1;
        run_to(u + 12);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_pv", period_valid, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_lost", lost, 0);
        chk("mid_rst_rise", rise, 0);
        rst = 1'b0;

        v = u + 20;
        run_to(v); set_sig(1);
        run_to(v + 4);
        chk("post_rst_arm_pv", period_valid, 0);
        chk("post_rst_arm_period", period, 0);
        run_to(v + 10); set_sig(0);
        run_to(v + 20); set_sig(1);
        run_to(v + 24);
        chk("post_rst_period", period, 20);
        chk("post_rst_pv", period_valid, 1);
        chk("post_rst_overrun", overrun, 0);
        run_to(v + 30); set_sig(0);
        run_to(v + 40);
        chk("rise_q_drained", rise_q.size(), 0);
        chk("fall_q_drained", fall_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
